// File: rtl/tx_libnet_512.sv
// Transmit half of libnet: stamps sequence numbers, enforces the send window, inserts ACK/SYN frames.
// Latency: one cycle from s_* to m_* through the output register stage.
// Backpressure: s_tready follows the output load enable; m_* is held stable while m_tvalid && !m_tready.
// Optional feature: define CONFIG_LIBNET_TX_SYN_ON_RESET_EN to send a SYN frame after every reset.
module tx_libnet_512 #(
    parameter int unsigned WINDOW = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [511:0] s_tdata,
    input  logic [63:0]  s_tkeep,
    input  logic [63:0]  s_tuser,
    input  logic         s_tlast,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [511:0] m_tdata,
    output logic [63:0]  m_tkeep,
    output logic [63:0]  m_tuser,
    output logic         m_tlast,
    output logic         m_tvalid,
    input  logic         m_tready,
    input  logic [31:0]  ack_seq,
    input  logic         ack_valid,
    input  logic [31:0]  rx_seq_expected,
    input  logic         rx_seq_valid
);

    localparam int SEQ_LSB  = 344;
    localparam int SEQ_MSB  = 375;
    localparam int ACK_FLAG = 376;
    localparam int SYN_FLAG = 377;
    localparam logic [31:0] WIN = WINDOW[31:0];

    typedef enum logic [1:0] {ST_IDLE, ST_SYN, ST_ACK, ST_STREAM} state_t;

    state_t       state_q, state_d;
    logic [31:0]  seq_next_q, seq_next_d;
    logic [31:0]  peer_ack_q, peer_ack_d;
    logic [31:0]  last_acked_q, last_acked_d;
    logic [511:0] m_tdata_q, m_tdata_d;
    logic [63:0]  m_tkeep_q, m_tkeep_d;
    logic [63:0]  m_tuser_q, m_tuser_d;
    logic         m_tlast_q, m_tlast_d;
    logic         m_tvalid_q, m_tvalid_d;

    logic [31:0]  outstanding;
    logic         win_open;
    logic         ack_pending;
    logic         syn_pending;
    logic         ld;
    logic         m_hs;
    logic         s_hs;
    logic         ack_accept;
    logic [511:0] hdr_dat;
    logic [511:0] syn_dat;
    logic [511:0] ack_dat;

    assign outstanding = seq_next_q - peer_ack_q;
    assign win_open    = outstanding < WIN;
    assign ack_pending = rx_seq_valid && (rx_seq_expected != last_acked_q);
    assign ld          = !m_tvalid_q || m_tready;
    assign m_hs        = m_tvalid_q && m_tready;
    // Held low in reset so the app never sees a handshake that the reset will discard.
    assign s_tready    = resetn && ld &&
                         ((state_q == ST_STREAM) ||
                          ((state_q == ST_IDLE) && !syn_pending && !ack_pending && win_open));
    assign s_hs        = s_tvalid && s_tready;
    // Cumulative ack is only credible if it lands within what we have actually sent.
    assign ack_accept  = ack_valid && ((ack_seq - peer_ack_q) <= outstanding);

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tuser  = m_tuser_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;

`ifdef CONFIG_LIBNET_TX_SYN_ON_RESET_EN
    logic syn_pending_q, syn_pending_d;

    // SYN request is armed by reset and retired once the SYN beat is taken downstream.
    always_comb begin
        syn_pending_d = syn_pending_q;
        if (state_q == ST_SYN && m_hs) begin
            syn_pending_d = 1'b0;
        end
    end

    // SYN request register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            syn_pending_q <= 1'b1;
        end else begin
            syn_pending_q <= syn_pending_d;
        end
    end

    assign syn_pending = syn_pending_q;
`else
    assign syn_pending = 1'b0;
`endif

    // Build the three possible output beat payloads.
    always_comb begin
        hdr_dat                      = s_tdata;
        hdr_dat[SYN_FLAG:SEQ_LSB]    = {2'b00, seq_next_q};
        syn_dat                      = '0;
        syn_dat[SEQ_MSB:SEQ_LSB]     = seq_next_q;
        syn_dat[SYN_FLAG]            = 1'b1;
        ack_dat                      = '0;
        ack_dat[SEQ_MSB:SEQ_LSB]     = rx_seq_expected;
        ack_dat[ACK_FLAG]            = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: frame selection only in IDLE, SYN > ACK > data; a packet is never interrupted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ld) begin
                    if (syn_pending) begin
                        state_d = ST_SYN;
                    end else if (ack_pending) begin
                        state_d = ST_ACK;
                    end else if (s_hs && !s_tlast) begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_SYN:    if (m_hs) state_d = ST_IDLE;
            ST_ACK:    if (m_hs) state_d = ST_IDLE;
            ST_STREAM: if (s_hs && s_tlast) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs and sequence bookkeeping: load the output stage whenever it is free.
    always_comb begin
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tuser_d    = m_tuser_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        seq_next_d   = seq_next_q;
        last_acked_d = last_acked_q;
        peer_ack_d   = ack_accept ? ack_seq : peer_ack_q;
        if (ld) begin
            m_tvalid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (syn_pending) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = syn_dat;
                        m_tkeep_d  = '1;
                        m_tuser_d  = '0;
                        m_tlast_d  = 1'b1;
                    end else if (ack_pending) begin
                        m_tvalid_d   = 1'b1;
                        m_tdata_d    = ack_dat;
                        m_tkeep_d    = '1;
                        m_tuser_d    = '0;
                        m_tlast_d    = 1'b1;
                        last_acked_d = rx_seq_expected;
                    end else if (s_hs) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = hdr_dat;
                        m_tkeep_d  = s_tkeep;
                        m_tuser_d  = s_tuser;
                        m_tlast_d  = s_tlast;
                        seq_next_d = seq_next_q + 32'd1;
                    end
                end
                ST_STREAM: begin
                    if (s_hs) begin
                        m_tvalid_d = 1'b1;
                        m_tdata_d  = s_tdata;
                        m_tkeep_d  = s_tkeep;
                        m_tuser_d  = s_tuser;
                        m_tlast_d  = s_tlast;
                    end
                end
                default: begin
                    m_tvalid_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tuser_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            seq_next_q   <= '0;
            peer_ack_q   <= '0;
            last_acked_q <= '0;
        end else begin
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tuser_q    <= m_tuser_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            seq_next_q   <= seq_next_d;
            peer_ack_q   <= peer_ack_d;
            last_acked_q <= last_acked_d;
        end
    end

endmodule

// File: tb/tb_tx_libnet_512.sv
// Bench for tx_libnet_512 with a 4-packet window.
// A reference model tracks sequence/ack state and expected output beats.
// Output stream is compared every handshake cycle; holds are checked on stalls.
module tb_tx_libnet_512;

    localparam int unsigned WIN = 4;
`ifdef CONFIG_LIBNET_TX_SYN_ON_RESET_EN
    localparam int EXP_SYN = 2;
`else
    localparam int EXP_SYN = 0;
`endif

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic [63:0]  u;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic [511:0] s_tdata;
    logic [63:0]  s_tkeep;
    logic [63:0]  s_tuser;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [511:0] m_tdata;
    logic [63:0]  m_tkeep;
    logic [63:0]  m_tuser;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b1;
    logic [31:0]  ack_seq;
    logic         ack_valid;
    logic [31:0]  rx_seq_expected;
    logic         rx_seq_valid;

    bit rnd_mode = 1'b0;

    always #5 clk = ~clk;

    tx_libnet_512 #(.WINDOW(WIN)) dut (
        .clk(clk), .resetn(resetn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .ack_seq(ack_seq), .ack_valid(ack_valid),
        .rx_seq_expected(rx_seq_expected), .rx_seq_valid(rx_seq_valid)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                     name, act.d, act.k, act.u, act.l, exp.d, exp.k, exp.u, exp.l);
        end
    endtask

    // Model state
    beat_t        exp_q[$];
    logic [31:0]  mdl_seq = '0;
    logic [31:0]  mdl_peer = '0;
    bit           in_pkt_in = 0;
    bit           in_pkt_out = 0;
    int           data_pkts_out = 0;
    int           ack_cnt = 0;
    int           syn_cnt = 0;
    int           cyc = 0;
    int           last_tlast_cyc = 0;
    int           ack_gap = 0;
    logic [31:0]  last_ack_seq = '0;
    logic [511:0] last_hdr = '0;
    beat_t        prev_m;
    bit           prev_stall = 0;

    always @(negedge clk) begin
        beat_t cur;
        beat_t b;
        beat_t e;
        bit    ack_acc;
        cyc++;
        cur = '{d: m_tdata, k: m_tkeep, u: m_tuser, l: m_tlast};
        if (!resetn) begin
            exp_q.delete();
            mdl_seq = '0;
            mdl_peer = '0;
            in_pkt_in = 0;
            in_pkt_out = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, m_tvalid}, 64'd1);
                chkb("hold_beat", cur, prev_m);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_m = cur;

            ack_acc = ack_valid && ((ack_seq - mdl_peer) <= (mdl_seq - mdl_peer));
            if (s_tvalid && s_tready) begin
                b = '{d: s_tdata, k: s_tkeep, u: s_tuser, l: s_tlast};
                if (!in_pkt_in) begin
                    chk("win_open_at_hdr", {63'd0, (mdl_seq - mdl_peer) < WIN}, 64'd1);
                    b.d[377:344] = {2'b00, mdl_seq};
                    mdl_seq = mdl_seq + 32'd1;
                end
                in_pkt_in = !s_tlast;
                exp_q.push_back(b);
            end
            if (ack_acc) mdl_peer = ack_seq;

            if (m_tvalid && m_tready) begin
                if (in_pkt_out || m_tdata[377:376] == 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_data_beat", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chkb("data_beat", cur, e);
                    end
                    if (!in_pkt_out) begin
                        data_pkts_out++;
                        last_hdr = m_tdata;
                    end
                    in_pkt_out = !m_tlast;
                    if (m_tlast) last_tlast_cyc = cyc;
                end else begin
                    e = '{d: '0, k: '1, u: '0, l: 1'b1};
                    if (m_tdata[377]) begin
                        e.d[377] = 1'b1;
                        e.d[375:344] = mdl_seq;
                        syn_cnt++;
                        chkb("syn_frame", cur, e);
                    end else begin
                        e.d[376] = 1'b1;
                        e.d[375:344] = rx_seq_expected;
                        ack_cnt++;
                        last_ack_seq = m_tdata[375:344];
                        ack_gap = cyc - last_tlast_cyc;
                        chkb("ack_frame", cur, e);
                    end
                end
            end
        end
    end

    // Downstream ready: fixed level or random per cycle.
    always @(posedge clk) begin
        #1;
        if (rnd_mode) m_tready = 1'($urandom_range(0, 1));
        else          m_tready = 1'b1;
    end

    function automatic logic [511:0] mk_data(input int id, input int i);
        logic [31:0] w;
        w = 32'hFF00_0000 | (32'(id) << 8) | 32'(i);
        return {16{w}};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers beats 0..nbeats-1 of a total-beat packet; leaves s_tvalid high on timeout.
    task automatic send_pkt(input int id, input int nbeats, input int total, input int maxw,
                            output bit ok);
        bit acc;
        ok = 1;
        for (int i = 0; i < nbeats; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = mk_data(id, i);
            s_tkeep  = 64'hFFFF_FFFF_FFFF_0000 | 64'(i);
            s_tuser  = {32'(id), 32'(i)};
            s_tlast  = (i == total - 1);
            acc = 0;
            for (int w = 0; w < maxw && !acc; w++) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                ok = 0;
                return;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic ack_pulse(input logic [31:0] v);
        ack_seq   = v;
        ack_valid = 1'b1;
        tick(1);
        ack_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < maxc) begin
            tick(1);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base;
        int nsent;
        resetn = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
        ack_seq = '0; ack_valid = 1'b0;
        rx_seq_expected = '0; rx_seq_valid = 1'b0;
        tick(4);
        @(negedge clk);
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
        chk("rst_m_tdata_any", {63'd0, |m_tdata}, 64'd0);
        chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

`ifdef CONFIG_LIBNET_TX_SYN_ON_RESET_EN
        for (int w = 0; w < 10 && !m_tvalid; w++) @(negedge clk);
        chk("syn_first_flag", {63'd0, m_tdata[377]}, 64'd1);
        chk("syn_first_seq", {32'd0, m_tdata[375:344]}, 64'd0);
        chk("syn_first_tlast", {63'd0, m_tlast}, 64'd1);
        tick(1);
`endif

        // 3-beat packet: header gets seq 0, flags cleared, body unchanged
        send_pkt(1, 3, 3, 50, ok);
        chk("pkt1_accepted", {63'd0, ok}, 64'd1);
        wait_drain(50);
        chk("pkt1_hdr_seq", {32'd0, last_hdr[375:344]}, 64'd0);
        chk("pkt1_hdr_flags", {62'd0, last_hdr[377:376]}, 64'd0);
        chk("pkt1_count", 64'(data_pkts_out), 64'd1);
        ack_pulse(32'd1);

        // Window of 4: seqs 1..4 go, fifth stalls
        base = data_pkts_out;
        nsent = 0;
        for (int p = 0; p < 6; p++) begin
            send_pkt(10 + p, 1, 1, 20, ok);
            if (!ok) break;
            nsent++;
        end
        tick(3);
        chk("win_sent_before_ack", 64'(data_pkts_out - base), 64'd4);
        chk("win_stall_ready", {63'd0, s_tready}, 64'd0);
        ack_pulse(32'd3);
        send_pkt(14, 1, 1, 20, ok);
        chk("win_reopen_a", {63'd0, ok}, 64'd1);
        send_pkt(15, 1, 1, 20, ok);
        chk("win_reopen_b", {63'd0, ok}, 64'd1);
        send_pkt(16, 1, 1, 20, ok);
        chk("win_stall_again", {63'd0, ok}, 64'd0);
        tick(2);
        chk("win_sent_after_ack", 64'(data_pkts_out - base), 64'd6);
        // Out-of-window ack is ignored: still stalled
        ack_pulse(32'd100);
        send_pkt(16, 1, 1, 20, ok);
        chk("stale_ack_ignored", {63'd0, ok}, 64'd0);
        ack_pulse(32'd7);
        send_pkt(16, 1, 1, 20, ok);
        chk("ack_all_reopens", {63'd0, ok}, 64'd1);
        wait_drain(50);
        chk("seq_after_window", {32'd0, last_hdr[375:344]}, 64'd7);
        ack_pulse(32'd8);

        // ACK frame inserted right after a streaming 4-beat packet
        fork
            begin
                send_pkt(30, 4, 4, 50, ok);
            end
            begin
                for (int w = 0; w < 50; w++) begin
                    @(negedge clk);
                    if (s_tvalid && s_tready) break;
                end
                @(posedge clk); #1;
                rx_seq_expected = 32'd7;
                rx_seq_valid = 1'b1;
            end
        join
        chk("ack_pkt_accepted", {63'd0, ok}, 64'd1);
        wait_drain(50);
        tick(10);
        chk("ack_count", 64'(ack_cnt), 64'd1);
        chk("ack_seq_val", {32'd0, last_ack_seq}, 64'd7);
        chk("ack_gap", 64'(ack_gap), 64'd1);
        ack_pulse(32'd9);

        // Random downstream stalls over 5-beat and 2-beat packets
        base = data_pkts_out;
        rnd_mode = 1'b1;
        send_pkt(40, 5, 5, 200, ok);
        chk("rnd_pkt_a", {63'd0, ok}, 64'd1);
        send_pkt(41, 2, 2, 200, ok);
        chk("rnd_pkt_b", {63'd0, ok}, 64'd1);
        wait_drain(300);
        rnd_mode = 1'b0;
        tick(2);
        chk("rnd_pkts_out", 64'(data_pkts_out - base), 64'd2);

        // Reset in the middle of a 4-beat packet
        rx_seq_valid = 1'b0;
        send_pkt(50, 2, 4, 50, ok);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);
        send_pkt(51, 1, 1, 50, ok);
        chk("post_rst_accepted", {63'd0, ok}, 64'd1);
        wait_drain(50);
        chk("post_rst_seq", {32'd0, last_hdr[375:344]}, 64'd0);
        chk("syn_total", 64'(syn_cnt), 64'(EXP_SYN));
        chk("ack_total", 64'(ack_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
